haar_filter_bank_mc: RTL and testbench
======================================

Name: haar_filter_bank_mc

Overview:
Multi-channel, multirate Haar analysis filter bank with valid/ready streaming on both sides. It accepts time-multiplexed samples tagged with a channel index and keeps independent per-channel, per-stage pairing state. Results are emitted serially as (channel, band, value) beats through a single output register that honours backpressure. It supersedes the single-channel, strobe-driven Haar bank in the miscFilters library.

Parameters:
STAGES, 4, number of LPF/HPF pair levels (1..8)
CHANNELS, 2, number of independent channels (1..16)
IN_WIDTH, 16, signed input sample width
INTERNAL_WIDTH, 18, signed internal datapath width
OUT_WIDTH, 16, signed output value width
CH_W, $clog2(CHANNELS) (min 1), channel index width (derived)
BAND_W, $clog2(STAGES+1), band index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
inValid  in  1  input beat valid
inReady  out  1  block can accept an input beat
inChannel  in  CH_W  channel of the input sample
inData  in  IN_WIDTH  signed input sample
outValid  out  1  output beat valid
outReady  in  1  downstream accepts the output beat
outChannel  out  CH_W  channel of the output beat
outBand  out  BAND_W  0 = final LP; STAGES-k = HP of stage k
outData  out  OUT_WIDTH  signed output value

Behaviour:
- Reset (async): FSM IDLE, all hold registers 0, all phase bits 0, outValid 0, outChannel/outBand/outData 0. inReady = (state==IDLE), so it reads 1 out of reset. Reset mid-cascade discards pending results.
- Input scaling: arithmetic shift left by INTERNAL_WIDTH-IN_WIDTH, or arithmetic shift right if IN_WIDTH is wider.
- Pair math (older a, newer b): sums are INTERNAL_WIDTH+1 bits. LP = (a+b)>>>1 and HP = (b-a)>>>1, keeping the upper INTERNAL_WIDTH bits (floor).
- Output scaling: arithmetic shift by the difference between INTERNAL_WIDTH and OUT_WIDTH, in either direction.
- FSM states: IDLE, STEP, EMIT_HP, EMIT_LP.
- IDLE: on inValid&&inReady, capture the scaled sample as carry, capture the channel, set k=0, and go to STEP. If inChannel >= CHANNELS, the beat is accepted and discarded, and the FSM stays in IDLE.
- STEP (1 cycle): if phase[ch][k]==0, store carry into hold[ch][k], set phase to 1, and go to IDLE. Otherwise compute LP/HP from hold and carry, clear phase, load the output register (band STAGES-k, value HP), assert outValid, set carry=LP, and go to EMIT_HP.
- EMIT_HP: on outValid&&outReady:
  - if k==STAGES-1, load band 0 with value LP and go to EMIT_LP;
  - else k++ and go to STEP; outValid drops for that cycle.
- EMIT_LP: on handshake, outValid goes to 0 and the FSM returns to IDLE.
- Latency: input accepted at cycle T gives outValid at T+2 (first HP). Each further stage adds 2 cycles plus stall time.
- Throughput: at most 1 input per 2 cycles; inReady is 0 during STEP/EMIT_*.
- Output register: fields stay stable while outValid && !outReady. No output beat is dropped or duplicated.
- Beats per channel for N = 2^STAGES inputs: 2^(STAGES-1) + ... + 1 HP beats plus 1 LP beat, N in total.
- Emission order within one cascade: band STAGES, STAGES-1, ..., down to band 0.

Optional Feature:
HAAR_ROUND_EN: when defined, LP/HP add 1 before >>>1 (round half up) and output narrowing adds half an LSB before shifting. This uses one extra bit, with saturation on overflow. When undefined, truncation is floor everywhere.

Decomposition:
- Package haar_pkg: state enum, band-index helper function, scale/round functions.
- Sub-module haar_pair_alu: combinational LP/HP computation plus scaling, including the HAAR_ROUND_EN variant. It is instantiated once and shared across stages and channels.

Test Plan:
- ch0 inputs 100 then 300 -> one beat {ch0, band4, 100}; no band3 beat.
- ch0 input 1000 ×16 -> 16 beats, all HP values 0. The cascade on the 16th sample emits bands 4,3,2,1,0, with band0 = 1000.
- Interleave ch0 = 100,300 and ch1 = 500,500 (alternating) -> {ch0, band4, 100} and {ch1, band4, 0}; no cross-channel mixing.
- outReady held low for 10 cycles during a 16th-sample cascade -> outData/outBand stable, inReady 0, all 5 beats delivered in order afterwards.
- Override IN=INTERNAL=OUT=16; ch0 inputs 0 then -1 -> band4 = -1. With HAAR_ROUND_EN defined -> band4 = 0.
- rst pulsed mid-cascade, then inputs 100,300 -> outValid 0 immediately on reset, and the first beat after reset is {ch0, band4, 100}; inChannel = CHANNELS is discarded with no output.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared types and arithmetic helpers for the multi-channel Haar analysis bank.
// Optional rounding is selected by HAAR_ROUND_EN in haar_pair_alu.
package haar_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STEP    = 2'd1,
    S_EMIT_HP = 2'd2,
    S_EMIT_LP = 2'd3
  } state_t;

  // Band 0 is the final LP; stage k high-pass lands on band STAGES-k.
  function automatic int unsigned band_of(int unsigned stages, int unsigned k);
    return stages - k;
  endfunction

  function automatic logic signed [63:0] sat_w(logic signed [63:0] x, int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Arithmetic width change; narrowing either floors or rounds half up with saturation.
  function automatic logic signed [63:0] rescale(logic signed [63:0] x, int unsigned from_w,
                                                 int unsigned to_w, bit rnd);
    if (to_w >= from_w) return x <<< (to_w - from_w);
    if (rnd) return sat_w((x + (64'sd1 <<< (from_w - to_w - 1))) >>> (from_w - to_w), to_w);
    return x >>> (from_w - to_w);
  endfunction

  // Halve a pair sum/difference back to w bits.
  function automatic logic signed [63:0] half(logic signed [63:0] x, int unsigned w, bit rnd);
    if (rnd) return sat_w((x + 64'sd1) >>> 1, w);
    return x >>> 1;
  endfunction

endpackage

// File: rtl/haar_pair_alu.sv
// Shared combinational Haar pair ALU: input scaling, LP/HP of (older a, newer b), output scaling.
// HAAR_ROUND_EN selects round-half-up with saturation instead of floor.
module haar_pair_alu #(
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned INTERNAL_WIDTH = 18,
  parameter int unsigned OUT_WIDTH      = 16
) (
  input  logic [IN_WIDTH-1:0]       i_sample,
  input  logic [INTERNAL_WIDTH-1:0] i_a,
  input  logic [INTERNAL_WIDTH-1:0] i_b,
  output logic [INTERNAL_WIDTH-1:0] o_sample_s,
  output logic [INTERNAL_WIDTH-1:0] o_lp,
  output logic [OUT_WIDTH-1:0]      o_hp_out,
  output logic [OUT_WIDTH-1:0]      o_b_out
);
  import haar_pkg::*;

`ifdef HAAR_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic signed [63:0] w_in64;
  logic signed [63:0] w_a64;
  logic signed [63:0] w_b64;
  logic signed [63:0] w_lp64;
  logic signed [63:0] w_hp64;

  assign w_in64 = 64'($signed(i_sample));
  assign w_a64  = 64'($signed(i_a));
  assign w_b64  = 64'($signed(i_b));

  assign w_lp64 = half(w_b64 + w_a64, INTERNAL_WIDTH, RND);
  assign w_hp64 = half(w_b64 - w_a64, INTERNAL_WIDTH, RND);

  assign o_sample_s = INTERNAL_WIDTH'(rescale(w_in64, IN_WIDTH, INTERNAL_WIDTH, 1'b0));
  assign o_lp       = INTERNAL_WIDTH'(w_lp64);
  assign o_hp_out   = OUT_WIDTH'(rescale(w_hp64, INTERNAL_WIDTH, OUT_WIDTH, RND));
  // Carry path: in EMIT_HP the carry already holds the final LP.
  assign o_b_out    = OUT_WIDTH'(rescale(w_b64, INTERNAL_WIDTH, OUT_WIDTH, RND));

endmodule

// File: rtl/haar_filter_bank_mc.sv
// Multi-channel multirate Haar analysis bank with valid/ready in and a single registered output beat.
// Rounding variant enabled by defining HAAR_ROUND_EN.
module haar_filter_bank_mc #(
  parameter int unsigned STAGES         = 4,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned INTERNAL_WIDTH = 18,
  parameter int unsigned OUT_WIDTH      = 16,
  parameter int unsigned CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int unsigned BAND_W         = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [CH_W-1:0]      inChannel,
  input  logic [IN_WIDTH-1:0]  inData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [CH_W-1:0]      outChannel,
  output logic [BAND_W-1:0]    outBand,
  output logic [OUT_WIDTH-1:0] outData
);
  import haar_pkg::*;

  localparam int unsigned K_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_t                    r_state;
  logic [INTERNAL_WIDTH-1:0] r_carry;
  logic [CH_W-1:0]           r_ch;
  logic [K_W-1:0]            r_k;
  logic [INTERNAL_WIDTH-1:0] r_hold [CHANNELS][STAGES];
  logic [STAGES-1:0]         r_phase [CHANNELS];
  logic                      r_out_valid;
  logic [CH_W-1:0]           r_out_ch;
  logic [BAND_W-1:0]         r_out_band;
  logic [OUT_WIDTH-1:0]      r_out_data;

  logic [INTERNAL_WIDTH-1:0] w_in_s;
  logic [INTERNAL_WIDTH-1:0] w_lp;
  logic [OUT_WIDTH-1:0]      w_hp_out;
  logic [OUT_WIDTH-1:0]      w_b_out;
  logic                      w_last_stage;
  logic                      w_ch_ok;

  haar_pair_alu #(
    .IN_WIDTH      (IN_WIDTH),
    .INTERNAL_WIDTH(INTERNAL_WIDTH),
    .OUT_WIDTH     (OUT_WIDTH)
  ) u_alu (
    .i_sample  (inData),
    .i_a       (r_hold[r_ch][r_k]),
    .i_b       (r_carry),
    .o_sample_s(w_in_s),
    .o_lp      (w_lp),
    .o_hp_out  (w_hp_out),
    .o_b_out   (w_b_out)
  );

  assign w_last_stage = (32'(r_k) == STAGES - 1);
  assign w_ch_ok      = (32'(inChannel) < CHANNELS);

  assign inReady    = (r_state == S_IDLE);
  assign outValid   = r_out_valid;
  assign outChannel = r_out_ch;
  assign outBand    = r_out_band;
  assign outData    = r_out_data;

  // Cascade FSM: one pairing stage per STEP, then hand the HP beat to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_carry     <= '0;
      r_ch        <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_band  <= '0;
      r_out_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_phase[c] <= '0;
        for (int s = 0; s < STAGES; s++) begin
          r_hold[c][s] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Out-of-range channels are swallowed without touching any state.
          if (inValid && w_ch_ok) begin
            r_carry <= w_in_s;
            r_ch    <= inChannel;
            r_k     <= '0;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          if (!r_phase[r_ch][r_k]) begin
            r_hold[r_ch][r_k]  <= r_carry;
            r_phase[r_ch][r_k] <= 1'b1;
            r_state            <= S_IDLE;
          end else begin
            r_phase[r_ch][r_k] <= 1'b0;
            r_out_valid        <= 1'b1;
            r_out_ch           <= r_ch;
            r_out_band         <= BAND_W'(band_of(STAGES, 32'(r_k)));
            r_out_data         <= w_hp_out;
            r_carry            <= w_lp;
            r_state            <= S_EMIT_HP;
          end
        end
        S_EMIT_HP: begin
          if (outReady) begin
            if (w_last_stage) begin
              r_out_band <= '0;
              r_out_data <= w_b_out;
              r_state    <= S_EMIT_LP;
            end else begin
              r_out_valid <= 1'b0;
              r_k         <= r_k + K_W'(1);
              r_state     <= S_STEP;
            end
          end
        end
        S_EMIT_LP: begin
          if (outReady) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_haar_filter_bank_mc.sv
// Scoreboard bench: stimulus pushes hand-computed beats, per-DUT monitors pop and compare on handshake.
module tb_haar_filter_bank_mc;

  typedef struct {
    int ch;
    int band;
    int data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [0:0]  a_in_ch, a_out_ch;
  logic [15:0] a_in_data, a_out_data;
  logic [2:0]  a_out_band;

  // DUT B: 1 stage, 3 channels, all widths 16
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_in_ch, b_out_ch;
  logic [15:0] b_in_data, b_out_data;
  logic [0:0]  b_out_band;

  haar_filter_bank_mc dut_a (
    .clk(clk), .rst(rst),
    .inValid(a_in_valid), .inReady(a_in_ready), .inChannel(a_in_ch), .inData(a_in_data),
    .outValid(a_out_valid), .outReady(a_out_ready), .outChannel(a_out_ch),
    .outBand(a_out_band), .outData(a_out_data)
  );

  haar_filter_bank_mc #(
    .STAGES(1), .CHANNELS(3), .IN_WIDTH(16), .INTERNAL_WIDTH(16), .OUT_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .inValid(b_in_valid), .inReady(b_in_ready), .inChannel(b_in_ch), .inData(b_in_data),
    .outValid(b_out_valid), .outReady(b_out_ready), .outChannel(b_out_ch),
    .outBand(b_out_band), .outData(b_out_data)
  );

  beat_t q_a[$];
  beat_t q_b[$];
  beat_t e_a, e_b;
  int checks = 0;
  int errors = 0;

`ifdef HAAR_ROUND_EN
  localparam int NEG_HALF = 0;
`else
  localparam int NEG_HALF = -1;
`endif

  // Monitors: a beat is consumed on the next posedge when valid && ready at the negedge.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected got ch=%0d band=%0d data=%0d", a_out_ch, a_out_band,
                 $signed(a_out_data));
      end else begin
        e_a = q_a.pop_front();
        if (int'(a_out_ch) != e_a.ch || int'(a_out_band) != e_a.band ||
            int'($signed(a_out_data)) != e_a.data) begin
          errors++;
          $display("FAIL a_beat got ch=%0d band=%0d data=%0d want ch=%0d band=%0d data=%0d",
                   a_out_ch, a_out_band, $signed(a_out_data), e_a.ch, e_a.band, e_a.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected got ch=%0d band=%0d data=%0d", b_out_ch, b_out_band,
                 $signed(b_out_data));
      end else begin
        e_b = q_b.pop_front();
        if (int'(b_out_ch) != e_b.ch || int'(b_out_band) != e_b.band ||
            int'($signed(b_out_data)) != e_b.data) begin
          errors++;
          $display("FAIL b_beat got ch=%0d band=%0d data=%0d want ch=%0d band=%0d data=%0d",
                   b_out_ch, b_out_band, $signed(b_out_data), e_b.ch, e_b.band, e_b.data);
        end
      end
    end
  end

  task automatic push_a(input int ch, input int band, input int data);
    beat_t b;
    b.ch = ch; b.band = band; b.data = data;
    q_a.push_back(b);
  endtask

  task automatic push_b(input int ch, input int band, input int data);
    beat_t b;
    b.ch = ch; b.band = band; b.data = data;
    q_b.push_back(b);
  endtask

  task automatic send_a(input int ch, input int data);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_ch    = 1'(ch);
    a_in_data  = 16'(data);
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL a_in_ready_timeout got 0 want 1");
        break;
      end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input int ch, input int data);
    int n;
    n = 0;
    b_in_valid = 1'b1;
    b_in_ch    = 2'(ch);
    b_in_data  = 16'(data);
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL b_in_ready_timeout got 0 want 1");
        break;
      end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
      @(posedge clk); n++;
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain got pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Ramp x_i = 16*(i-1): HP per stage is 8,16,32,64 and final LP is 120.
  task automatic push_ramp(input int i);
    if (i % 2 == 0)  push_a(0, 4, 8);
    if (i % 4 == 0)  push_a(0, 3, 16);
    if (i % 8 == 0)  push_a(0, 2, 32);
    if (i == 16) begin
      push_a(0, 1, 64);
      push_a(0, 0, 120);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] hold_data;
    logic [2:0]  hold_band;
    int n;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_ch = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_ch = '0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 16'd0 ||
        a_out_band !== 3'd0 || a_out_ch !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b d=%0d band=%0d ch=%0d want 0 1 0 0 0",
               a_out_valid, a_in_ready, a_out_data, a_out_band, a_out_ch);
    end
    rst = 1'b0;

    // Single pair: only the stage-0 HP comes out.
    push_a(0, 4, 100);
    send_a(0, 100);
    send_a(0, 300);
    drain();

    // DC input: all HP zero, final LP equals the input.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      if (i % 2 == 0) push_a(0, 4, 0);
      if (i % 4 == 0) push_a(0, 3, 0);
      if (i % 8 == 0) push_a(0, 2, 0);
      if (i == 16) begin
        push_a(0, 1, 0);
        push_a(0, 0, 1000);
      end
      send_a(0, 1000);
    end
    drain();

    // Interleaved channels keep separate pairing state.
    do_reset();
    send_a(0, 100);
    send_a(1, 500);
    push_a(0, 4, 100);
    send_a(0, 300);
    push_a(1, 4, 0);
    send_a(1, 500);
    drain();

    // Ramp with backpressure on the final cascade.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      push_ramp(i);
      send_a(0, 16 * (i - 1));
    end
    drain();
    a_out_ready = 1'b0;
    push_ramp(16);
    send_a(0, 240);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (a_out_valid !== 1'b1 || a_out_band !== 3'd4 || a_out_data !== 16'd8) begin
      errors++;
      $display("FAIL stall_first got v=%b band=%0d data=%0d want 1 4 8", a_out_valid, a_out_band,
               $signed(a_out_data));
    end
    hold_data = a_out_data;
    hold_band = a_out_band;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== hold_data || a_out_band !== hold_band ||
          a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got v=%b band=%0d data=%0d rdy=%b want 1 %0d %0d 0",
                 a_out_valid, a_out_band, $signed(a_out_data), a_in_ready, hold_band,
                 $signed(hold_data));
      end
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain();

    // Reset while a cascade is stalled discards the pending beats.
    do_reset();
    send_a(0, 1000);
    push_a(0, 4, 0);
    send_a(0, 1000);
    send_a(0, 1000);
    drain();
    a_out_ready = 1'b0;
    send_a(0, 1000);
    n = 0;
    while (!a_out_valid && n < 50) begin
      @(negedge clk); n++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%b data=%0d rdy=%b want 0 0 1", a_out_valid,
               $signed(a_out_data), a_in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    push_a(0, 4, 100);
    send_a(0, 100);
    send_a(0, 300);
    drain();

    // DUT B: out-of-range channel dropped, -1/2 floor vs round, third channel.
    send_b(3, 77);
    send_b(0, 0);
    push_b(0, 1, NEG_HALF);
    push_b(0, 0, NEG_HALF);
    send_b(0, -1);
    send_b(2, 20);
    push_b(2, 1, -5);
    push_b(2, 0, 15);
    send_b(2, 10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
